// File: rtl/pcm_mix_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pcm_mix_pkg
//  Description : Shared types and constants for the PCM voice mixer: FSM
//                state encoding, sample midscale, clamp bounds and the
//                accumulator width helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package pcm_mix_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        SAT   = 2'd2
    } mix_state_t;

    localparam logic [7:0] MIDSCALE = 8'h80;
    localparam int         SAT_MAX  = 127;
    localparam int         SAT_MIN  = -128;

    // Signed accumulator must hold NUM_CH full-scale centred samples plus sign.
    function automatic int acc_width(input int num_ch, input int sample_w);
        return sample_w + $clog2(num_ch) + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sigma_delta_dac.sv
`default_nettype none
// ============================================================================
//  Module      : sigma_delta_dac
//  Description : First-order sigma-delta modulator. The carry out of an 8-bit
//                phase accumulator is the 1-bit output, giving a pulse
//                density of din/256.
//  Revision    : 1.0 - initial release
// ============================================================================
module sigma_delta_dac (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] din,
    output logic       dout
);

    logic [7:0] r_sd;
    logic       r_dout;
    logic [8:0] w_sum;

    assign w_sum = {1'b0, r_sd} + {1'b0, din};
    assign dout  = r_dout;

    // Accumulate every cycle; the carry of the new sum becomes the output bit.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sd   <= '0;
            r_dout <= 1'b0;
        end else begin
            r_sd   <= w_sum[7:0];
            r_dout <= w_sum[8];
        end
    end

endmodule
`default_nettype wire

// File: rtl/pcm_voice_mixer.sv
`default_nettype none
// ============================================================================
//  Module      : pcm_voice_mixer
//  Description : Buffers one PCM sample per channel, sums the enabled channels
//                serially into a signed accumulator, applies gain, saturates
//                back to unsigned 8-bit and drives a sigma-delta output pin.
//  Revision    : 1.0 - initial release
// ============================================================================
module pcm_voice_mixer
    import pcm_mix_pkg::*;
#(
    parameter int NUM_CH   = 8,
    parameter int SAMPLE_W = 8,
    parameter int ACC_W    = acc_width(NUM_CH, SAMPLE_W)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_CH*SAMPLE_W-1:0] pcm_in,
    input  logic [NUM_CH-1:0]          pcm_vld,
    output logic [NUM_CH-1:0]          pcm_rdy,
    input  logic [NUM_CH-1:0]          ch_mask,
    input  logic [1:0]                 gain,
    output logic [SAMPLE_W-1:0]        mix_out,
    output logic                       mix_vld,
    output logic                       dac_out
);

    localparam int                         IDX_W      = $clog2(NUM_CH);
    localparam logic [IDX_W-1:0]           C_LAST_IDX = IDX_W'(NUM_CH - 1);
    localparam logic signed [ACC_W-1:0]    C_ACC_MAX  = ACC_W'(SAT_MAX);
    localparam logic signed [ACC_W-1:0]    C_ACC_MIN  = ACC_W'(SAT_MIN);
    localparam logic [SAMPLE_W-1:0]        C_OUT_MAX  = SAMPLE_W'(SAT_MAX) ^ MIDSCALE;
    localparam logic [SAMPLE_W-1:0]        C_OUT_MIN  = SAMPLE_W'(SAT_MIN) ^ MIDSCALE;

    mix_state_t                 r_state;
    mix_state_t                 w_state_nxt;
    logic [NUM_CH-1:0]          r_full;
    logic [SAMPLE_W-1:0]        r_hold [NUM_CH];
    logic [NUM_CH-1:0]          r_mask;
    logic [1:0]                 r_gain;
    logic [IDX_W-1:0]           r_idx;
    logic signed [ACC_W-1:0]    r_acc;
    logic [SAMPLE_W-1:0]        r_mix;
    logic                       r_mix_vld;

    logic                       w_all_full;
    logic [SAMPLE_W-1:0]        w_centered;
    logic signed [ACC_W-1:0]    w_addend;
    logic [1:0]                 w_shamt;
    logic signed [ACC_W-1:0]    w_shifted;
    logic [SAMPLE_W-1:0]        w_clamped;

    // A masked channel is always ready so its producer never stalls.
    assign pcm_rdy    = ~ch_mask | ~r_full;
    assign w_all_full = (ch_mask != '0) && ((r_full & ch_mask) == ch_mask);

    // Unsigned sample to signed offset around midscale, sign-extended.
    assign w_centered = r_hold[r_idx] ^ MIDSCALE;
    assign w_addend   = {{(ACC_W-SAMPLE_W){w_centered[SAMPLE_W-1]}}, w_centered};
    assign w_shamt    = 2'd3 - r_gain;
    assign w_shifted  = r_acc >>> w_shamt;

    assign mix_out = r_mix;
    assign mix_vld = r_mix_vld;

    // Clamp the scaled sum to the signed 8-bit range and recentre it.
    always_comb begin
        w_clamped = w_shifted[SAMPLE_W-1:0] ^ MIDSCALE;
        if (w_shifted > C_ACC_MAX) begin
            w_clamped = C_OUT_MAX;
        end else if (w_shifted < C_ACC_MIN) begin
            w_clamped = C_OUT_MIN;
        end
    end

    // Per-channel one-deep buffers: the SAT clear frees the mixed channels,
    // channels masked off while idle are flushed, full buffers are never overwritten.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_full <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                r_hold[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (r_state == SAT && r_mask[i]) begin
                    r_full[i] <= 1'b0;
                end else if (r_state == IDLE && !ch_mask[i]) begin
                    r_full[i] <= 1'b0;
                end else if (pcm_vld[i] && pcm_rdy[i] && ch_mask[i]) begin
                    r_full[i] <= 1'b1;
                    r_hold[i] <= pcm_in[i*SAMPLE_W +: SAMPLE_W];
                end
            end
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state: wait for every enabled channel, walk all channels, saturate.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_all_full)          w_state_nxt = ACCUM;
            ACCUM:   if (r_idx == C_LAST_IDX) w_state_nxt = SAT;
            SAT:                              w_state_nxt = IDLE;
            default:                          w_state_nxt = IDLE;
        endcase
    end

    // Mix datapath: snapshot mask/gain at start so later changes do not
    // disturb the mix in flight; accumulate one channel per cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_mask    <= '0;
            r_gain    <= '0;
            r_idx     <= '0;
            r_acc     <= '0;
            r_mix     <= MIDSCALE;
            r_mix_vld <= 1'b0;
        end else begin
            r_mix_vld <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_all_full) begin
                        r_mask <= ch_mask;
                        r_gain <= gain;
                        r_acc  <= '0;
                        r_idx  <= '0;
                    end
                end
                ACCUM: begin
                    if (r_mask[r_idx]) begin
                        r_acc <= r_acc + w_addend;
                    end
                    r_idx <= r_idx + 1'b1;
                end
                SAT: begin
                    r_mix     <= w_clamped;
                    r_mix_vld <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    sigma_delta_dac u_dac (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (r_mix),
        .dout  (dac_out)
    );

endmodule
`default_nettype wire

// File: tb/tb_pcm_voice_mixer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pcm_voice_mixer
//  Description : Directed testbench for pcm_voice_mixer. Stimulus pushes the
//                hand-computed mix result and its due cycle into a queue; a
//                monitor pops and compares on every mix_vld pulse.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pcm_voice_mixer;

    logic        clk     = 1'b0;
    logic        rst_n   = 1'b0;
    logic [63:0] pcm_in  = '0;
    logic [7:0]  pcm_vld = '0;
    logic [7:0]  pcm_rdy;
    logic [7:0]  ch_mask = '0;
    logic [1:0]  gain    = '0;
    logic [7:0]  mix_out;
    logic        mix_vld;
    logic        dac_out;

    typedef struct {
        logic [7:0] val;
        int         cyc;
        int         tag;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   cyc      = 0;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   tag_n    = 0;

    pcm_voice_mixer #(
        .NUM_CH   (8),
        .SAMPLE_W (8)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .pcm_in  (pcm_in),
        .pcm_vld (pcm_vld),
        .pcm_rdy (pcm_rdy),
        .ch_mask (ch_mask),
        .gain    (gain),
        .mix_out (mix_out),
        .mix_vld (mix_vld),
        .dac_out (dac_out)
    );

    always #5 clk = ~clk;

    // Edge counter: after posedge k, cyc == k.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    // Queue the expected mix; acc_cyc < 0 skips the latency comparison.
    task automatic expect_mix(input logic [7:0] val, input int acc_cyc);
        exp_t e;
        e.val = val;
        e.cyc = (acc_cyc >= 0) ? acc_cyc + 10 : -1;
        e.tag = tag_n;
        tag_n++;
        exp_q.push_back(e);
    endtask

    // Present samples on the channels in vm; drop each valid once accepted.
    task automatic load(input logic [7:0] vm, input logic [63:0] data, output int acc_cyc);
        logic [7:0] w;
        int n;
        pcm_in  = data;
        pcm_vld = vm;
        acc_cyc = -1;
        n = 0;
        while (pcm_vld != 8'h00 && n < 50) begin
            @(negedge clk);
            w = pcm_vld & pcm_rdy;
            @(posedge clk);
            #1;
            pcm_vld = pcm_vld & ~w;
            if (w != 8'h00) acc_cyc = cyc;
            n++;
        end
        if (pcm_vld != 8'h00) begin
            n_checks++;
            n_fail++;
            $display("FAIL load_timeout: pending valid %02h, required all accepted", pcm_vld);
            pcm_vld = '0;
        end
    endtask

    // Wait until every queued result has been seen, then idle a while so a
    // spurious extra pulse would be caught by the monitor.
    task automatic wait_drain();
        for (int i = 0; i < 40 && exp_q.size() != 0; i++) begin
            @(negedge clk);
            #1;
        end
        if (exp_q.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain_timeout: %0d results outstanding, required 0", exp_q.size());
            exp_q.delete();
        end
        repeat (12) @(posedge clk);
        #1;
    endtask

    // Monitor: every mix_vld pulse must match the oldest expectation.
    always @(negedge clk) begin
        if (mix_vld === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_mix_vld: mix_out=%02h, required no pulse", mix_out);
            end else begin
                mon_e = exp_q.pop_front();
                check($sformatf("mix_out[%0d]", mon_e.tag), mix_out, mon_e.val);
                if (mon_e.cyc >= 0)
                    check($sformatf("mix_latency[%0d]", mon_e.tag), cyc, mon_e.cyc);
            end
        end
    end

    logic [7:0]  t_mask [6];
    logic [1:0]  t_gain [6];
    logic [63:0] t_data [6];
    logic [7:0]  t_exp  [6];

    initial begin
        int   ac;
        int   ones;
        logic prev;
        logic got;

        // Saturation / gain / partial-mask vectors.
        t_mask[0] = 8'hFF; t_gain[0] = 2'd3; t_data[0] = {8{8'hFF}}; t_exp[0] = 8'hFF;
        t_mask[1] = 8'hFF; t_gain[1] = 2'd0; t_data[1] = {8{8'hFF}}; t_exp[1] = 8'hFF;
        t_mask[2] = 8'hFF; t_gain[2] = 2'd3; t_data[2] = {8{8'h00}}; t_exp[2] = 8'h00;
        t_mask[3] = 8'hFF; t_gain[3] = 2'd1; t_data[3] = {8{8'h90}}; t_exp[3] = 8'hA0;
        t_mask[4] = 8'hFF; t_gain[4] = 2'd2; t_data[4] = {8{8'h70}}; t_exp[4] = 8'h40;
        t_mask[5] = 8'hA5; t_gain[5] = 2'd3;
        t_data[5] = {8'h78, 8'h55, 8'h88, 8'h55, 8'h55, 8'hA0, 8'h55, 8'h90};
        t_exp[5]  = 8'hB0;

        // Reset state
        rst_n   = 1'b0;
        ch_mask = 8'hFF;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_mix_out", mix_out, 8'h80);
        check("rst_mix_vld", mix_vld, 1'b0);
        check("rst_dac_out", dac_out, 1'b0);
        check("rst_pcm_rdy", pcm_rdy, 8'hFF);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // All channels at midscale, gain 0
        gain = 2'd0;
        load(8'hFF, {8{8'h80}}, ac);
        expect_mix(8'h80, ac);
        wait_drain();
        @(negedge clk);
        prev = dac_out;
        repeat (6) begin
            @(negedge clk);
            check("dac_alternate", dac_out, !prev);
            prev = dac_out;
        end
        @(posedge clk);
        #1;

        // Two opposing channels cancel; masked channels never stall
        ch_mask = 8'h03;
        gain    = 2'd3;
        load(8'hFF, {{6{8'h55}}, 8'h40, 8'hC0}, ac);
        expect_mix(8'h80, ac);
        repeat (12) begin
            @(negedge clk);
            check("masked_rdy", pcm_rdy[7:2], 6'h3F);
        end
        wait_drain();

        // Saturation and gain table
        for (int k = 0; k < 6; k++) begin
            ch_mask = t_mask[k];
            gain    = t_gain[k];
            load(8'hFF, t_data[k], ac);
            expect_mix(t_exp[k], ac);
            wait_drain();
        end

        // Backpressure on a full channel
        ch_mask = 8'h01;
        gain    = 2'd3;
        load(8'h01, {56'h0, 8'h90}, ac);
        expect_mix(8'h90, ac);
        pcm_in[7:0] = 8'h11;
        pcm_vld     = 8'h01;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (mix_vld) begin
                check("bp_rdy_at_mix", pcm_rdy[0], 1'b1);
                got = 1'b1;
            end else begin
                check("bp_rdy_stall", pcm_rdy[0], 1'b0);
            end
        end
        if (!got) begin
            n_checks++;
            n_fail++;
            $display("FAIL bp_timeout: mix_vld=0, required a pulse");
        end
        @(posedge clk);
        #1;
        pcm_vld = '0;
        expect_mix(8'h11, cyc);
        wait_drain();

        // Mask shrinks during ACCUM: the running mix keeps both channels
        ch_mask = 8'h03;
        gain    = 2'd3;
        load(8'h03, {48'h0, 8'hA0, 8'h90}, ac);
        expect_mix(8'hB0, ac);
        repeat (3) @(posedge clk);
        #1;
        ch_mask = 8'h01;
        wait_drain();

        // ch1 filled, then masked off in IDLE: flushed, next mix is ch0 only
        ch_mask = 8'h03;
        load(8'h02, {48'h0, 8'hF0, 8'h00}, ac);
        ch_mask = 8'h01;
        load(8'h01, {56'h0, 8'h88}, ac);
        expect_mix(8'h88, ac);
        wait_drain();
        ch_mask = 8'h03;
        @(negedge clk);
        check("flush_rdy", pcm_rdy[1:0], 2'b11);
        @(posedge clk);
        #1;

        // Reset pulse in the middle of ACCUM
        ch_mask = 8'hFF;
        gain    = 2'd3;
        load(8'hFF, {8{8'hFF}}, ac);
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("midrst_mix_out", mix_out, 8'h80);
        check("midrst_mix_vld", mix_vld, 1'b0);
        check("midrst_pcm_rdy", pcm_rdy, 8'hFF);
        check("midrst_dac_out", dac_out, 1'b0);
        repeat (15) @(posedge clk);
        #1;

        // Normal mixing after reset, then pulse density of 0xC0 (3 of 4)
        ch_mask = 8'h01;
        load(8'h01, {56'h0, 8'hC0}, ac);
        expect_mix(8'hC0, ac);
        wait_drain();
        ones = 0;
        repeat (64) begin
            @(negedge clk);
            if (dac_out) ones++;
        end
        check("dac_density_c0", ones, 48);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
